// File: rtl/reorder_buffer.sv
// reorder_buffer: circular 15-entry ROB with in-order commit, rename requests and branch rollback.
// Define ROB_BYPASS_EN to forward a same-cycle CDB broadcast to the operand queries.
module reorder_buffer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic             issue_pred_taken,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  output logic             renaming_valid,
  output logic [4:0]       renaming_reg_id,
  output logic [TAG_W-1:0] renaming_alias,
  input  logic [TAG_W-1:0] query1_tag,
  input  logic [TAG_W-1:0] query2_tag,
  output logic             query1_ready,
  output logic             query2_ready,
  output logic [31:0]      query1_value,
  output logic [31:0]      query2_value,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [31:0]      wb_target,
  output logic             commit_valid,
  output logic [4:0]       commit_reg_id,
  output logic [TAG_W-1:0] commit_alias,
  output logic [31:0]      commit_value,
  output logic             store_commit_valid,
  output logic [TAG_W-1:0] store_commit_tag,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);
  localparam int N = (1 << TAG_W) - 1;
  typedef enum logic [1:0] {T_REG, T_STORE, T_BRANCH, T_RSVD} rob_type_e;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [N:0] busy_q, busy_d, ready_q, ready_d, pred_q, pred_d, taken_q, taken_d;
  rob_type_e type_q [N:0];
  rob_type_e type_d [N:0];
  logic [4:0] rd_q [N:0];
  logic [4:0] rd_d [N:0];
  logic [31:0] value_q [N:0];
  logic [31:0] value_d [N:0];
  logic [31:0] target_q [N:0];
  logic [31:0] target_d [N:0];
  logic cv_q, cv_d, sv_q, sv_d, rb_q, rb_d;
  logic [4:0] crd_q, crd_d;
  logic [TAG_W-1:0] ca_q, ca_d, st_q, st_d;
  logic [31:0] cval_q, cval_d, rpc_q, rpc_d;
  logic issue_ok, wb_ok, head_wb, do_commit, mispredict, h_taken, byp1, byp2;
  logic [31:0] h_value, h_target;

  function automatic logic [TAG_W-1:0] inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(N)) ? TAG_W'(1) : p + TAG_W'(1);
  endfunction

  assign rob_full        = count_q == TAG_W'(N);
  assign issue_tag       = tail_q;
  assign issue_ok        = rdy && issue_valid && !rob_full && !rb_q;
  assign renaming_valid  = issue_ok && issue_type != T_STORE && issue_rd != 5'd0;
  assign renaming_reg_id = renaming_valid ? issue_rd : 5'd0;
  assign renaming_alias  = renaming_valid ? tail_q : '0;
  assign wb_ok           = rdy && wb_valid && busy_q[wb_tag];
  // A broadcast to the head this cycle lets it commit without waiting a cycle in storage
  assign head_wb         = wb_ok && wb_tag == head_q;
  assign do_commit       = rdy && busy_q[head_q] && (ready_q[head_q] || head_wb);
  assign h_value         = head_wb ? wb_value : value_q[head_q];
  assign h_taken         = head_wb ? wb_taken : taken_q[head_q];
  assign h_target        = head_wb ? wb_target : target_q[head_q];
  assign mispredict      = do_commit && type_q[head_q] == T_BRANCH && h_taken != pred_q[head_q];

`ifdef ROB_BYPASS_EN
  assign byp1 = wb_ok && query1_tag != '0 && wb_tag == query1_tag;
  assign byp2 = wb_ok && query2_tag != '0 && wb_tag == query2_tag;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign query1_ready = byp1 || (busy_q[query1_tag] && ready_q[query1_tag]);
  assign query2_ready = byp2 || (busy_q[query2_tag] && ready_q[query2_tag]);
  assign query1_value = byp1 ? wb_value : query1_ready ? value_q[query1_tag] : 32'd0;
  assign query2_value = byp2 ? wb_value : query2_ready ? value_q[query2_tag] : 32'd0;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    pred_d   = pred_q;
    taken_d  = taken_q;
    type_d   = type_q;
    rd_d     = rd_q;
    value_d  = value_q;
    target_d = target_q;
    count_d  = count_q + TAG_W'(issue_ok) - TAG_W'(do_commit);
    if (wb_ok) begin
      ready_d[wb_tag]  = 1'b1;
      value_d[wb_tag]  = wb_value;
      taken_d[wb_tag]  = wb_taken;
      target_d[wb_tag] = wb_target;
    end
    if (issue_ok) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      type_d[tail_q]  = rob_type_e'(issue_type);
      rd_d[tail_q]    = issue_rd;
      pred_d[tail_q]  = issue_pred_taken;
      tail_d          = inc(tail_q);
    end
    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = inc(head_q);
    end
    // Flush at the commit edge so the rollback cycle already sees an empty buffer
    if (mispredict) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = TAG_W'(1);
      tail_d  = TAG_W'(1);
      count_d = '0;
    end
    cv_d   = do_commit && type_q[head_q] != T_STORE && rd_q[head_q] != 5'd0;
    crd_d  = cv_d ? rd_q[head_q] : 5'd0;
    ca_d   = cv_d ? head_q : '0;
    cval_d = cv_d ? h_value : 32'd0;
    sv_d   = do_commit && type_q[head_q] == T_STORE;
    st_d   = sv_d ? head_q : '0;
    rb_d   = mispredict;
    rpc_d  = mispredict ? h_target : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= TAG_W'(1);
      tail_q  <= TAG_W'(1);
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      cv_q    <= 1'b0;
      crd_q   <= '0;
      ca_q    <= '0;
      cval_q  <= '0;
      sv_q    <= 1'b0;
      st_q    <= '0;
      rb_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      pred_q   <= pred_d;
      taken_q  <= taken_d;
      type_q   <= type_d;
      rd_q     <= rd_d;
      value_q  <= value_d;
      target_q <= target_d;
      cv_q     <= cv_d;
      crd_q    <= crd_d;
      ca_q     <= ca_d;
      cval_q   <= cval_d;
      sv_q     <= sv_d;
      st_q     <= st_d;
      rb_q     <= rb_d;
      rpc_q    <= rpc_d;
    end
  end

  assign commit_valid       = cv_q;
  assign commit_reg_id      = crd_q;
  assign commit_alias       = ca_q;
  assign commit_value       = cval_q;
  assign store_commit_valid = sv_q;
  assign store_commit_tag   = st_q;
  assign rollback           = rb_q;
  assign rollback_pc        = rpc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus checked against a program-order queue model of the ROB.
module tb_reorder_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rdy, iv, ipred, wv, wtk;
  logic [1:0] ityp;
  logic [4:0] ird;
  logic [3:0] q1t, q2t, wt;
  logic [31:0] wval, wtgt;
  logic [3:0] issue_tag, ren_alias, commit_alias, store_tag;
  logic rob_full, ren_valid, q1r, q2r, commit_valid, store_valid, rollback;
  logic [4:0] ren_id, commit_reg_id;
  logic [31:0] q1v, q2v, commit_value, rollback_pc;

  reorder_buffer #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(iv), .issue_type(ityp), .issue_rd(ird), .issue_pred_taken(ipred),
    .issue_tag(issue_tag), .rob_full(rob_full),
    .renaming_valid(ren_valid), .renaming_reg_id(ren_id), .renaming_alias(ren_alias),
    .query1_tag(q1t), .query2_tag(q2t), .query1_ready(q1r), .query2_ready(q2r),
    .query1_value(q1v), .query2_value(q2v),
    .wb_valid(wv), .wb_tag(wt), .wb_value(wval), .wb_taken(wtk), .wb_target(wtgt),
    .commit_valid(commit_valid), .commit_reg_id(commit_reg_id), .commit_alias(commit_alias),
    .commit_value(commit_value), .store_commit_valid(store_valid), .store_commit_tag(store_tag),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred, done, taken;
    logic [31:0] value, target;
  } ent_t;

  ent_t q[$];
  logic [3:0] m_tail;
  logic e_cv, e_sv, e_rb;
  logic [4:0] e_crd;
  logic [3:0] e_ca, e_st;
  logic [31:0] e_cval, e_rpc;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int find(input logic [3:0] t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  function automatic void mq(input logic [3:0] t, output logic r, output logic [31:0] v);
    int i = find(t);
    r = 1'b0;
    v = 32'd0;
    if (i >= 0 && q[i].done) begin r = 1'b1; v = q[i].value; end
`ifdef ROB_BYPASS_EN
    if (i >= 0 && rdy && wv && wt == t) begin r = 1'b1; v = wval; end
`endif
  endfunction

  function automatic logic accepted();
    return rdy && iv && q.size() < 15 && !e_rb;
  endfunction

  task automatic compare_all();
    logic r;
    logic [31:0] v;
    logic ren;
    ren = accepted() && ityp != 2'd1 && ird != 5'd0;
    chk("issue_tag", issue_tag, m_tail);
    chk("rob_full", rob_full, q.size() == 15);
    chk("ren_valid", ren_valid, ren);
    chk("ren_id", ren_id, ren ? ird : 5'd0);
    chk("ren_alias", ren_alias, ren ? m_tail : 4'd0);
    mq(q1t, r, v);
    chk("q1_ready", q1r, r);
    chk("q1_value", q1v, v);
    mq(q2t, r, v);
    chk("q2_ready", q2r, r);
    chk("q2_value", q2v, v);
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_reg", commit_reg_id, e_crd);
    chk("commit_alias", commit_alias, e_ca);
    chk("commit_value", commit_value, e_cval);
    chk("store_valid", store_valid, e_sv);
    chk("store_tag", store_tag, e_st);
    chk("rollback", rollback, e_rb);
    chk("rollback_pc", rollback_pc, e_rpc);
  endtask

  task automatic model_update();
    logic acc;
    int i;
    ent_t e;
    acc = accepted();
    {e_cv, e_sv, e_rb, e_crd, e_ca, e_st, e_cval, e_rpc} = '0;
    if (rst) begin
      q.delete();
      m_tail = 4'd1;
    end else if (rdy) begin
      i = wv ? find(wt) : -1;
      if (i >= 0) begin
        q[i].done = 1'b1; q[i].value = wval; q[i].taken = wtk; q[i].target = wtgt;
      end
      if (acc) begin
        q.push_back('{tag: m_tail, typ: ityp, rd: ird, pred: ipred, done: 1'b0, taken: 1'b0,
                      value: 32'd0, target: 32'd0});
        m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
      end
      if (q.size() > 0 && q[0].done) begin
        e = q.pop_front();
        if (e.typ == 2'd1) begin e_sv = 1'b1; e_st = e.tag; end
        else if (e.rd != 5'd0) begin e_cv = 1'b1; e_crd = e.rd; e_ca = e.tag; e_cval = e.value; end
        if (e.typ == 2'd2 && e.taken != e.pred) begin
          e_rb = 1'b1; e_rpc = e.target;
          q.delete();
          m_tail = 4'd1;
        end
      end
    end
  endtask

  task automatic idle();
    {iv, ityp, ird, ipred, q1t, q2t, wv, wt, wval, wtk, wtgt, rst} = '0;
    rdy = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; cyc(); idle();
  endtask

  function automatic logic [3:0] pick();
    if (q.size() > 0 && $urandom % 4 != 0) return q[$urandom_range(0, q.size() - 1)].tag;
    return 4'($urandom % 16);
  endfunction

  initial begin
    int k;
    q.delete(); m_tail = 4'd1;
    {e_cv, e_sv, e_rb, e_crd, e_ca, e_st, e_cval, e_rpc} = '0;
    do_reset();
    chk_en = 1;
    idle(); settle();
    chk("rst_issue_tag", issue_tag, 1); chk("rst_commit", commit_valid, 0); chk("rst_rollback", rollback, 0);
    tick();
    idle(); iv = 1; ird = 5; settle();
    chk("t1_ren_valid", ren_valid, 1); chk("t1_ren_id", ren_id, 5); chk("t1_ren_alias", ren_alias, 1);
    tick();
    idle(); wv = 1; wt = 1; wval = 32'h1234; cyc();
    idle(); settle();
    chk("t1_cv", commit_valid, 1); chk("t1_reg", commit_reg_id, 5);
    chk("t1_alias", commit_alias, 1); chk("t1_value", commit_value, 32'h1234);
    tick();
    do_reset();
    for (int i = 0; i < 15; i++) begin idle(); iv = 1; ird = 5'(i + 1); cyc(); end
    idle(); iv = 1; ird = 9; settle();
    chk("full", rob_full, 1); chk("full_drop", ren_valid, 0);
    tick();
    idle(); wv = 1; wt = 1; wval = 32'haa; cyc();
    idle(); settle(); chk("full_commit_alias", commit_alias, 1); chk("full_after", rob_full, 0); tick();
    idle(); iv = 1; ird = 3; settle(); chk("wrap_tag", issue_tag, 1); chk("wrap_alias", ren_alias, 1); tick();
    idle(); wv = 1; wt = 4; wval = 44; cyc();
    idle(); wv = 1; wt = 3; wval = 33; settle(); chk("ooo_hold", commit_valid, 0); tick();
    idle(); wv = 1; wt = 2; wval = 22; cyc();
    idle(); settle(); chk("ooo_a2", commit_alias, 2); chk("ooo_v2", commit_value, 22); tick();
    idle(); settle(); chk("ooo_a3", commit_alias, 3); tick();
    idle(); settle(); chk("ooo_a4", commit_alias, 4); tick();
    idle(); settle(); chk("ooo_done", commit_valid, 0); tick();
    idle(); wv = 1; wt = 6; wval = 7; q1t = 6; settle();
`ifdef ROB_BYPASS_EN
    chk("byp_ready", q1r, 1); chk("byp_value", q1v, 7);
`else
    chk("nobyp_ready", q1r, 0);
`endif
    tick();
    idle(); q1t = 6; settle(); chk("q_ready_next", q1r, 1); chk("q_value_next", q1v, 7); tick();
    do_reset();
    idle(); iv = 1; ityp = 2; ipred = 0; cyc();
    idle(); iv = 1; ird = 3; cyc();
    idle(); wv = 1; wt = 1; wtk = 1; wtgt = 32'h100; cyc();
    idle(); iv = 1; ird = 4; settle();
    chk("rb", rollback, 1); chk("rb_pc", rollback_pc, 32'h100); chk("rb_block", ren_valid, 0); chk("rb_cv", commit_valid, 0);
    tick();
    idle(); settle(); chk("rb_tag", issue_tag, 1); chk("rb_full", rob_full, 0); chk("rb_pulse", rollback, 0); tick();
    idle(); wv = 1; wt = 2; cyc();
    idle(); settle(); chk("rb_flushed", commit_valid, 0); tick();
    idle(); iv = 1; ityp = 1; ird = 7; settle(); chk("st_noren", ren_valid, 0); tick();
    idle(); wv = 1; wt = 1; cyc();
    idle(); settle(); chk("st_valid", store_valid, 1); chk("st_tag", store_tag, 1); chk("st_cv", commit_valid, 0); tick();
    idle(); iv = 1; ird = 8; cyc();
    idle(); rdy = 0; wv = 1; wt = 2; cyc();
    idle(); settle(); chk("rdy_frozen", commit_valid, 0); tick();
    idle(); rdy = 0; rst = 1; cyc();
    idle(); settle(); chk("midrst_tag", issue_tag, 1); tick();
    for (int n = 0; n < 4000; n++) begin
      idle();
      rdy = ($urandom % 10) != 0;
      rst = ($urandom % 400) == 0;
      iv = ($urandom % 10) < 6;
      ityp = 2'($urandom % 3);
      ird = 5'($urandom);
      ipred = 1'($urandom);
      q1t = pick();
      q2t = pick();
      wv = 1'($urandom);
      wval = $urandom;
      wtgt = $urandom;
      wtk = 1'($urandom);
      if (q.size() > 0 && $urandom % 4 != 0) begin
        k = $urandom_range(0, q.size() - 1);
        wt = q[k].tag;
        if (q[k].typ == 2'd2) wtk = q[k].pred ^ (($urandom % 6) == 0);
      end else wt = 4'($urandom % 16);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer of the Tomasulo core. It allocates a ROB tag to every instruction the dispatcher issues and drives the register-rename request for that tag. It collects results from the common data bus and commits in program order to the register file (commit_* port) and the load/store buffer. On a mispredicted branch reaching the head, it raises `rollback` and flushes itself.

## Interface
- TAG_W, 4, tag width; usable tags 1..2^TAG_W-1 (15 entries); tag 0 means "no dependency"
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- issue_valid  in  1  dispatcher issues an instruction this cycle
- issue_type  in  2  0 REG, 1 STORE, 2 BRANCH (BRANCH may also write rd, e.g. JALR)
- issue_rd  in  5  destination register
- issue_pred_taken  in  1  predictor decision
- issue_tag  out  TAG_W  tag to be assigned to the current issue (= tail)
- rob_full  out  1  all 15 entries occupied
- renaming_valid / renaming_reg_id / renaming_alias  out  1/5/TAG_W  rename request to register file
- query1_tag, query2_tag  in  TAG_W  operand tags from dispatcher
- query1_ready, query2_ready  out  1  entry holds its result
- query1_value, query2_value  out  32  that result
- wb_valid  in  1  CDB broadcast
- wb_tag  in  TAG_W
- wb_value  in  32
- wb_taken  in  1  actual branch outcome
- wb_target  in  32  correct next PC if mispredicted
- commit_valid  out  1  register write to register file
- commit_reg_id  out  5
- commit_alias  out  TAG_W
- commit_value  out  32
- store_commit_valid  out  1  head store may write memory
- store_commit_tag  out  TAG_W
- rollback  out  1  flush pulse to all units
- rollback_pc  out  32  fetch redirect

## Operation
- State: head, tail in 1..15; count 0..15; per entry busy, ready, type, rd, value, pred_taken, real_taken, target.
- Pointer increment wraps 15 -> 1; tag 0 is never allocated.
- Issue accepted when issue_valid && !rob_full && !rollback: entry[tail] gets busy=1, ready=0; tail advances.
- Dispatcher must not issue while rob_full; an issue while full is dropped.
- renaming_valid = issue accepted && issue_type != STORE && issue_rd != 0. renaming_reg_id = issue_rd; renaming_alias = tail. These outputs are combinational.
- Writeback: wb_valid && entry[wb_tag].busy sets ready=1 and latches value, real_taken and target. wb to a non-busy tag is ignored.
- Commit: at most one per cycle, when entry[head].busy && ready.
  - STORE: store_commit_valid=1, store_commit_tag=head.
  - REG or BRANCH with rd != 0: commit_valid=1, reg_id=rd, alias=head, value=value.
  - BRANCH with real_taken != pred_taken: rollback=1, rollback_pc=target; the rd write, if any, still commits in the same cycle.
  - head advances and the entry is cleared.
- Rollback cycle (rollback registered high): all busy cleared, head=tail=1, count=0. Issue and wb in that cycle are ignored.
- Issue and commit in the same cycle leave count unchanged.
- Queries are combinational. ready = entry busy && ready; tag 0 returns ready=0, value=0.

## Timing
- Reset values: every output 0 except issue_tag=1. head=tail=1, count=0, all busy=0.
- commit_*, store_commit_*, rollback and rollback_pc are registered and pulse for exactly one cycle, the cycle after the head is found ready.
- Writeback-to-commit latency: 1 cycle minimum, meaning wb at cycle N gives commit output high at N+1 for the head entry.
- rob_full is combinational from count (count==15). It does not look ahead at the issue of the current cycle.
- rdy low: no state changes; registered pulse outputs drop to 0.
- Reset mid-operation discards all entries regardless of rdy.

## Configuration
- ROB_BYPASS_EN defined: a query whose tag equals wb_tag while wb_valid returns ready=1 and value=wb_value in the same cycle.
- ROB_BYPASS_EN undefined: queries reflect stored entry state only, one cycle after writeback.

## Test plan
- Reset, issue REG rd=5 -> issue_tag=1, renaming_valid=1, reg_id=5, alias=1. Then wb tag1 value 0x1234 -> next cycle commit_valid=1, reg_id=5, alias=1, value=0x1234.
- Issue 15 REG instructions -> rob_full=1 and a 16th issue is dropped. Commit one, then issue -> tag 1 is reused after tail wraps 15 -> 1.
- Issue tags 1,2,3; wb in order 3,2,1 -> commits occur in order 1,2,3 on consecutive cycles.
- Issue BRANCH pred_taken=0, then REG; wb branch taken=1 target 0x100 -> rollback=1, rollback_pc=0x100. Next cycle count=0 and issue_tag=1.
- Issue STORE at tag 1, wb -> store_commit_valid=1, store_commit_tag=1, commit_valid=0.
- With ROB_BYPASS_EN: query1_tag=2 while wb_tag=2 value 7 -> query1_ready=1, value=7 in the same cycle. Without it, ready=0 that cycle and ready=1 the next.
